spi_slave_4wire_sync: RTL and testbench
=======================================

Name: spi_slave_4wire_sync

Overview:
- Oversampled 4-wire SPI slave (responder), all logic in the system clk domain.
- Pairs with the team's SPI master on the far end of the link. Used in loopback and on boards where an FPGA is the SPI target.
- Synchronises cs_n/sclk/mosi, shifts one DATA_WIDTH-bit word per frame, MSB first, full duplex.
- User side: ready/valid TX holding register and a one-cycle RX valid pulse.

Parameters:
- SPI_MODE, 3, SPI mode 0..3; CPOL=SPI_MODE[1], CPHA=SPI_MODE[0].
- DATA_WIDTH, 16, bits per frame, minimum 2.
- TX_UNDERRUN_FILL, all-ones, word shifted out when no TX word is loaded.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; synchronous, active-low.
- cs_n  in  1  chip select from master, asynchronous.
- sclk  in  1  SPI clock from master, asynchronous.
- mosi  in  1  master-out data, asynchronous.
- miso  out  1  slave-out data, registered.
- miso_oe  out  1  tristate enable for miso; 1 while a frame is active.
- tx_data  in  DATA_WIDTH  word for the next frame.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX holding register empty.
- rx_data  out  DATA_WIDTH  last complete received word, held until overwritten.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse: frame started with no TX word loaded.
- frame_err  out  1  one-cycle pulse: cs_n rose before DATA_WIDTH bits were received.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0. The TX holding register is empty, the bit counter is 0 and the state is IDLE.
- Synchronisers:
  - 2-FF synchronisers on cs_n, sclk and mosi, plus one extra delay register each on cs_n and sclk for edge detection.
  - On reset, the cs_n chain resets to 0 and the sclk chain resets to CPOL.
  - A cs_n falling edge is prev=1 and cur=0. If cs_n is already low when reset releases, no false frame start occurs; the block waits for cs_n high and then a genuine fall.
- Edges:
  - leading = sclk leaves CPOL; trailing = sclk returns to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. The shift edge is the other one.
  - mosi is taken from its sync stage 2 in the same cycle the sclk edge is detected, so both have equal latency.
- TX holding register:
  - tx_valid && tx_ready loads the register and tx_ready drops.
  - At frame start the register transfers to the shift register and tx_ready rises again on the next cycle.
  - If the register is empty at frame start, TX_UNDERRUN_FILL is loaded instead and tx_underrun pulses.
  - A load in the same cycle as frame start goes to the holding register for the next frame, not the current one.
- FSM:
  - IDLE -> ACTIVE on cs_n fall: load TX shift register, counter=0, miso_oe=1. If CPHA=0, miso=MSB on the next clk.
  - ACTIVE, shift edge: miso = next bit. If CPHA=1, the first leading edge presents the MSB.
  - ACTIVE, sample edge: shift in mosi, counter+1. When the counter reaches DATA_WIDTH, rx_data <= word and rx_valid pulses on the next clk; go to DONE.
  - ACTIVE -> IDLE on cs_n rise: frame_err pulse, partial word discarded, no rx_valid.
  - DONE: further sclk edges are ignored and miso=0. -> IDLE on cs_n rise with no error.
  - IDLE: miso=0, miso_oe=0.
- Latency: miso changes 3 clk after the master's sclk edge. rx_valid asserts 4 clk after the last sample edge.
- Master timing constraint on the same clk: SCLK period >= 8 clk and CS-to-first-SCLK-edge >= 4 clk.
- rstn low mid-frame: abort immediately with no pulses; resume at the next genuine cs_n fall.

Decomposition:
- Package spi_pkg holds:
  - state enum {IDLE, ACTIVE, DONE};
  - functions cpol(mode) and cpha(mode);
  - bit-counter width constant $clog2(DATA_WIDTH+1).
- One sub-module, spi_in_sync: 2-FF synchroniser with a parameterised reset value, a delay register, and rise/fall pulse outputs. Instantiated for cs_n and sclk; a plain 2-FF path serves mosi.

Test Plan:
All scenarios use the team SPI master on the same clk with SCLK period 8 and TCC 4.
1. Mode 3, DW=16, slave preloaded with 0xA5C3, master sends 0x1234 -> rx_data=0x1234 with a single rx_valid pulse; master receives 0xA5C3; tx_ready=1 one clk after frame start.
2. Repeat scenario 1 in modes 0, 1 and 2 with words 0x8001/0x7FFE -> exact exchange in every mode, and miso_oe is high only while cs_n is low (with sync delay).
3. No TX load, master sends 0x00FF -> master receives 0xFFFF; tx_underrun pulses once; rx_data=0x00FF.
4. cs_n raised after 7 sclk cycles, then a full frame 0x0F0F -> one frame_err pulse and no rx_valid for the first frame; second frame rx_data=0x0F0F.
5. rstn low for 3 clk mid-frame while cs_n stays low -> no rx_valid and no frame_err for that frame; the next full frame 0x5AA5 is received correctly.
6. Frame with 20 sclk cycles, data 0xBEEF then 4 junk bits -> rx_valid exactly once with 0xBEEF; miso=0 during the extra bits.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the oversampled SPI slave.
package spi_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Clock polarity: idle level of sclk.
    function automatic logic cpol(input int unsigned mode);
        return 1'((mode >> 1) & 1);
    endfunction

    // Clock phase: 0 samples on the leading edge, 1 on the trailing edge.
    function automatic logic cpha(input int unsigned mode);
        return 1'(mode & 1);
    endfunction

    // Bit counter must hold 0..dw inclusive.
    function automatic int unsigned cnt_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

    localparam int unsigned CNT_W_DEFAULT = $clog2(DATA_WIDTH_DEFAULT + 1);

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchroniser plus delay stage producing single-cycle edge pulses.
module spi_in_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Next-state of the synchroniser chain and the edge-detect delay stage.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Chain registers; reset to the line's idle-safe value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Edge pulses compare the synchronised level with its delayed copy.
    always_comb begin
        rise_c = s2_q & ~s3_q;
        fall_c = ~s2_q & s3_q;
    end

endmodule

// File: rtl/spi_slave_4wire_sync.sv
// Oversampled 4-wire SPI slave: one full-duplex word per cs_n frame, MSB first.
module spi_slave_4wire_sync
    import spi_pkg::*;
#(
    parameter int unsigned              SPI_MODE         = 3,
    parameter int unsigned              DATA_WIDTH       = 16,
    parameter logic [DATA_WIDTH-1:0]    TX_UNDERRUN_FILL = '1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cs_n,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_err
);

    localparam logic        CPOL  = cpol(SPI_MODE);
    localparam logic        CPHA  = cpha(SPI_MODE);
    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

    logic cs_rise_c, cs_fall_c, sclk_rise_c, sclk_fall_c;
    logic lead_c, trail_c, sample_c, shift_c;
    logic mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   frame_err_q, frame_err_d;
    logic                   word_done_q, word_done_d;

    // cs_n chain resets low so a select already asserted at reset release is not a frame start.
    spi_in_sync #(.RST_VAL(1'b0)) u_cs_sync (
        .clk    (clk),
        .rstn   (rstn),
        .d      (cs_n),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    // sclk chain resets to its idle level so reset release creates no edge.
    spi_in_sync #(.RST_VAL(CPOL)) u_sclk_sync (
        .clk    (clk),
        .rstn   (rstn),
        .d      (sclk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // Map physical edges onto leading/trailing and then onto sample/shift roles.
    always_comb begin
        lead_c   = CPOL ? sclk_fall_c : sclk_rise_c;
        trail_c  = CPOL ? sclk_rise_c : sclk_fall_c;
        sample_c = CPHA ? trail_c : lead_c;
        shift_c  = CPHA ? lead_c  : trail_c;
        mosi_s1_d = mosi;
        mosi_s2_d = mosi_s1_q;
    end

    // Frame FSM, shift register, TX holding register and user-side pulses.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        hold_d        = hold_q;
        tx_ready_d    = tx_ready_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = word_done_q;
        tx_underrun_d = 1'b0;
        frame_err_d   = 1'b0;
        word_done_d   = 1'b0;

        if (word_done_q) begin
            rx_data_d = shreg_q;
        end

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall_c) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    if (!tx_ready_q) begin
                        shreg_d    = hold_q;
                        tx_ready_d = 1'b1;
                    end else begin
                        shreg_d       = TX_UNDERRUN_FILL;
                        tx_underrun_d = 1'b1;
                    end
                    if (!CPHA) begin
                        miso_d = shreg_d[DATA_WIDTH-1];
                    end
                end
            end
            ACTIVE: begin
                if (cs_rise_c) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else if (sample_c) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], mosi_s2_q};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_d     = DONE;
                        word_done_d = 1'b1;
                        miso_d      = 1'b0;
                    end
                end else if (shift_c) begin
                    miso_d = shreg_q[DATA_WIDTH-1];
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_rise_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase

        // A load coinciding with frame start lands in the holding register for the next frame.
        if (tx_valid && tx_ready_q) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end

        miso_oe_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mosi_s1_q     <= 1'b0;
            mosi_s2_q     <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            hold_q        <= '0;
            tx_ready_q    <= 1'b1;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
            word_done_q   <= 1'b0;
        end else begin
            mosi_s1_q     <= mosi_s1_d;
            mosi_s2_q     <= mosi_s2_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            hold_q        <= hold_d;
            tx_ready_q    <= tx_ready_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_err_q   <= frame_err_d;
            word_done_q   <= word_done_d;
        end
    end

    always_comb begin
        miso        = miso_q;
        miso_oe     = miso_oe_q;
        tx_ready    = tx_ready_q;
        rx_data     = rx_data_q;
        rx_valid    = rx_valid_q;
        tx_underrun = tx_underrun_q;
        frame_err   = frame_err_q;
    end

endmodule

// File: tb/tb_spi_slave_4wire_sync.sv
// Directed bench: one slave per SPI mode, driven by a cycle-based master model.
module tb_spi_slave_4wire_sync;

    logic        clk;
    logic        rstn;
    logic        mosi;
    logic [15:0] tx_data;
    logic        cs_n_a        [4];
    logic        sclk_a        [4];
    logic        tx_valid_a    [4];
    logic        miso_a        [4];
    logic        miso_oe_a     [4];
    logic        tx_ready_a    [4];
    logic [15:0] rx_data_a     [4];
    logic        rx_valid_a    [4];
    logic        tx_underrun_a [4];
    logic        frame_err_a   [4];

    int rxv_cnt  [4];
    int und_cnt  [4];
    int ferr_cnt [4];

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_4wire_sync #(
            .SPI_MODE   (g),
            .DATA_WIDTH (16)
        ) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .cs_n        (cs_n_a[g]),
            .sclk        (sclk_a[g]),
            .mosi        (mosi),
            .miso        (miso_a[g]),
            .miso_oe     (miso_oe_a[g]),
            .tx_data     (tx_data),
            .tx_valid    (tx_valid_a[g]),
            .tx_ready    (tx_ready_a[g]),
            .rx_data     (rx_data_a[g]),
            .rx_valid    (rx_valid_a[g]),
            .tx_underrun (tx_underrun_a[g]),
            .frame_err   (frame_err_a[g])
        );
    end

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_valid_a[k])    rxv_cnt[k]  = rxv_cnt[k] + 1;
            if (tx_underrun_a[k]) und_cnt[k]  = und_cnt[k] + 1;
            if (frame_err_a[k])   ferr_cnt[k] = ferr_cnt[k] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_tx(input int m, input logic [15:0] w);
        @(negedge clk);
        tx_data       = w;
        tx_valid_a[m] = 1'b1;
        @(negedge clk);
        tx_valid_a[m] = 1'b0;
        check_eq("tx_ready_after_load", 32'(tx_ready_a[m]), 32'd0);
    endtask

    // Master: SCLK period 8 clk, CS-to-first-edge 4 clk; optional reset pulse before bit rst_at.
    task automatic xfer(input int m, input logic [31:0] w, input int nbits,
                        input int rst_at, output logic [31:0] rx);
        logic pol;
        logic pha;
        pol = 1'((m >> 1) & 1);
        pha = 1'(m & 1);
        rx  = '0;
        @(negedge clk);
        cs_n_a[m] = 1'b0;
        if (!pha) mosi = w[nbits-1];
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rstn = 1'b0;
                repeat (3) @(negedge clk);
                rstn = 1'b1;
            end
            sclk_a[m] = ~pol;
            if (!pha) rx = {rx[30:0], miso_a[m]};
            else      mosi = w[nbits-1-i];
            if (i == 0 && rst_at < 0) check_eq("oe_in_frame", 32'(miso_oe_a[m]), 32'd1);
            repeat (4) @(negedge clk);
            sclk_a[m] = pol;
            if (pha)              rx = {rx[30:0], miso_a[m]};
            else if (i < nbits-1) mosi = w[nbits-2-i];
            repeat (4) @(negedge clk);
        end
        cs_n_a[m] = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("oe_after_frame", 32'(miso_oe_a[m]), 32'd0);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [31:0] mrx;
        int b_rxv;
        int b_und;
        int b_ferr;
        n_vec   = 0;
        n_err   = 0;
        rstn    = 1'b0;
        mosi    = 1'b0;
        tx_data = '0;
        for (int k = 0; k < 4; k++) begin
            cs_n_a[k]     = 1'b1;
            sclk_a[k]     = 1'((k >> 1) & 1);
            tx_valid_a[k] = 1'b0;
            rxv_cnt[k]    = 0;
            und_cnt[k]    = 0;
            ferr_cnt[k]   = 0;
        end
        repeat (4) @(negedge clk);
        check_eq("rst_miso",     32'(miso_a[3]),     32'd0);
        check_eq("rst_miso_oe",  32'(miso_oe_a[3]),  32'd0);
        check_eq("rst_tx_ready", 32'(tx_ready_a[3]), 32'd1);
        check_eq("rst_rx_data",  32'(rx_data_a[3]),  32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid_a[3]), 32'd0);
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        // Scenario 1: mode 3 exchange.
        load_tx(3, 16'hA5C3);
        b_rxv = rxv_cnt[3]; b_und = und_cnt[3];
        xfer(3, 32'h1234, 16, -1, mrx);
        check_eq("m3_rx_data",  32'(rx_data_a[3]), 32'h1234);
        check_eq("m3_master",   mrx,               32'hA5C3);
        check_eq("m3_rx_valid", 32'(rxv_cnt[3] - b_rxv), 32'd1);
        check_eq("m3_no_under", 32'(und_cnt[3] - b_und), 32'd0);
        check_eq("m3_tx_ready", 32'(tx_ready_a[3]), 32'd1);

        // Scenario 2: modes 0..2.
        for (int m = 0; m < 3; m++) begin
            load_tx(m, 16'h8001);
            b_rxv = rxv_cnt[m];
            xfer(m, 32'h7FFE, 16, -1, mrx);
            check_eq("mx_rx_data",  32'(rx_data_a[m]), 32'h7FFE);
            check_eq("mx_master",   mrx,               32'h8001);
            check_eq("mx_rx_valid", 32'(rxv_cnt[m] - b_rxv), 32'd1);
        end

        // Scenario 3: underrun.
        b_und = und_cnt[3];
        xfer(3, 32'h00FF, 16, -1, mrx);
        check_eq("under_master",  mrx,               32'hFFFF);
        check_eq("under_pulse",   32'(und_cnt[3] - b_und), 32'd1);
        check_eq("under_rx_data", 32'(rx_data_a[3]), 32'h00FF);

        // Scenario 4: short frame then full frame.
        load_tx(3, 16'h3C3C);
        b_rxv = rxv_cnt[3]; b_ferr = ferr_cnt[3];
        xfer(3, 32'h55, 7, -1, mrx);
        check_eq("short_ferr",   32'(ferr_cnt[3] - b_ferr), 32'd1);
        check_eq("short_no_rxv", 32'(rxv_cnt[3] - b_rxv),   32'd0);
        check_eq("short_master", mrx, 32'h1E);
        b_rxv = rxv_cnt[3]; b_ferr = ferr_cnt[3];
        xfer(3, 32'h0F0F, 16, -1, mrx);
        check_eq("after_short_rx",   32'(rx_data_a[3]), 32'h0F0F);
        check_eq("after_short_rxv",  32'(rxv_cnt[3] - b_rxv),   32'd1);
        check_eq("after_short_ferr", 32'(ferr_cnt[3] - b_ferr), 32'd0);

        // Scenario 5: reset mid-frame.
        load_tx(3, 16'h1357);
        b_rxv = rxv_cnt[3]; b_ferr = ferr_cnt[3];
        xfer(3, 32'hFFFF, 16, 5, mrx);
        check_eq("rst_mid_no_rxv",  32'(rxv_cnt[3] - b_rxv),   32'd0);
        check_eq("rst_mid_no_ferr", 32'(ferr_cnt[3] - b_ferr), 32'd0);
        check_eq("rst_mid_rx_data", 32'(rx_data_a[3]),  32'd0);
        check_eq("rst_mid_ready",   32'(tx_ready_a[3]), 32'd1);
        load_tx(3, 16'h2468);
        xfer(3, 32'h5AA5, 16, -1, mrx);
        check_eq("post_rst_rx",     32'(rx_data_a[3]), 32'h5AA5);
        check_eq("post_rst_master", mrx,               32'h2468);

        // Scenario 6: over-long frame.
        load_tx(3, 16'h1357);
        b_rxv = rxv_cnt[3]; b_ferr = ferr_cnt[3];
        xfer(3, 32'hBEEFA, 20, -1, mrx);
        check_eq("long_rx_data", 32'(rx_data_a[3]), 32'hBEEF);
        check_eq("long_rxv",     32'(rxv_cnt[3] - b_rxv),   32'd1);
        check_eq("long_no_ferr", 32'(ferr_cnt[3] - b_ferr), 32'd0);
        check_eq("long_master",  mrx, 32'h13570);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
